// File: rtl/gen_pkg.sv
// rtl/gen_pkg.sv - shared types and helpers for the generator collector
package gen_pkg;

    localparam int GEN_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        COLLECT = 2'd2,
        DONE    = 2'd3
    } gen_state_t;

    // A value moves across the generator handshake only when both sides agree.
    function automatic logic gen_xfer(input logic ready, input logic valid);
        return ready && valid;
    endfunction

endpackage

// File: rtl/gen_fifo.sv
// rtl/gen_fifo.sv - first-word-fall-through FIFO for yielded generator values
module gen_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     _clock,
    input  logic                     _reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_fire;
    logic             wr_fire;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    // A read in the same cycle frees the slot, so a full FIFO can still take a write.
    assign rd_fire = rd_en && !empty;
    assign wr_fire = wr_en && (!full || rd_fire);
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because level gates visibility.
    always_ff @(posedge _clock) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_fire, rd_fire})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/gen_collector.sv
// rtl/gen_collector.sv - caller-side terminal that launches and drains a generator
module gen_collector
    import gen_pkg::*;
#(
    parameter int WIDTH = GEN_WIDTH,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   _clock,
    input  logic                   _reset,
    input  logic                   cmd_start,
    input  logic [WIDTH-1:0]       arg_base,
    input  logic [WIDTH-1:0]       arg_limit,
    input  logic [WIDTH-1:0]       arg_step,
    output logic                   gen_start,
    output logic                   gen_reset,
    output logic                   gen_ready,
    input  logic                   gen_valid,
    input  logic                   gen_done,
    input  logic [WIDTH-1:0]       gen_0,
    output logic [WIDTH-1:0]       gen_base,
    output logic [WIDTH-1:0]       gen_limit,
    output logic [WIDTH-1:0]       gen_step,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       total,
    output logic                   busy,
    output logic                   finished
);

    gen_state_t state_q;
    gen_state_t state_d;
    logic       fifo_full;
    logic       rd_fire;
    logic       launch_acc;
    logic       push;

    assign rd_fire    = rd_en && !empty;
    assign launch_acc = cmd_start && ((state_q == IDLE) || (state_q == DONE));
    assign push       = (state_q == COLLECT) && gen_xfer(gen_ready, gen_valid);
    assign busy       = (state_q == LAUNCH) || (state_q == COLLECT);
    assign finished   = (state_q == DONE);

    gen_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        ._clock  (_clock),
        ._reset  (_reset),
        .wr_en   (push),
        .wr_data (gen_0),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (fifo_full),
        .level   (level)
    );

    // State register.
    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and generator handshake; done/valid are only trusted in COLLECT.
    always_comb begin
        state_d   = state_q;
        gen_start = 1'b0;
        gen_reset = 1'b0;
        gen_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                gen_reset = 1'b1;
                if (cmd_start) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                gen_start = 1'b1;
                state_d   = COLLECT;
            end
            COLLECT: begin
                gen_ready = !fifo_full || rd_fire;
                if (gen_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (cmd_start) begin
                    state_d = LAUNCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Argument latch on an accepted launch; cleared only by reset.
    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            gen_base  <= '0;
            gen_limit <= '0;
            gen_step  <= '0;
        end else if (launch_acc) begin
            gen_base  <= arg_base;
            gen_limit <= arg_limit;
            gen_step  <= arg_step;
        end
    end

    // Per-run count of accepted values, saturating at all-ones.
    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            total <= '0;
        end else if (launch_acc) begin
            total <= '0;
        end else if (push && (total != {CNT_W{1'b1}})) begin
            total <= total + 1'b1;
        end
    end

endmodule
